clint: RTL

Core-local interruptor for the single-hart core. It owns the machine timer (`mtime`), the timer compare register (`mtimecmp`) and the software-interrupt register (`msip`), all accessed through a simple memory-mapped slave port. It drives the timer and software interrupt request lines that the CSR file samples into `mip`. The external interrupt line comes from the PLIC and does not pass through this block.

---
 rtl/clint.sv | 129 ++++++++++++
 1 files changed

// File: rtl/clint.sv
// Core-local interruptor: machine timer, timer compare and software
// interrupt registers behind a single-cycle memory-mapped slave port.
module clint #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        irq_software_o,
  output logic        irq_timer_o
);

  localparam int unsigned DATA_W = 32;

  localparam logic [15:0] ADDR_MSIP     = 16'h0000;
  localparam logic [15:0] ADDR_MTCMP_LO = 16'h4000;
  localparam logic [15:0] ADDR_MTCMP_HI = 16'h4004;
  localparam logic [15:0] ADDR_MTIME_LO = 16'hBFF8;
  localparam logic [15:0] ADDR_MTIME_HI = 16'hBFFC;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  logic [15:0]       presc_p0;
  logic              tick_p0;
  logic [63:0]       mtime_p0;
  logic [63:0]       mtimecmp_p0;
  logic              msip_p0;

  logic              wr_p0;
  logic              rd_p0;
  logic              wr_mtime_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] rdata_p1;
  logic              irq_sw_p1;
  logic              irq_tm_p1;

  // Register read multiplexer; unmapped offsets read as zero.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic [15:0] addr,
    input logic [63:0] mtime,
    input logic [63:0] mtimecmp,
    input logic        msip
  );
    logic [DATA_W-1:0] val;
    val = '0;
    case (addr)
      ADDR_MSIP:     val = {31'd0, msip};
      ADDR_MTCMP_LO: val = mtimecmp[31:0];
      ADDR_MTCMP_HI: val = mtimecmp[63:32];
      ADDR_MTIME_LO: val = mtime[31:0];
      ADDR_MTIME_HI: val = mtime[63:32];
      default:       val = '0;
    endcase
    return val;
  endfunction

  assign wr_p0       = req_i & we_i;
  assign rd_p0       = req_i & ~we_i;
  assign wr_mtime_p0 = wr_p0 & ((addr_i == ADDR_MTIME_LO) | (addr_i == ADDR_MTIME_HI));
  assign tick_p0     = (presc_p0 == TICK_LAST);

  // Free-running prescaler; bus traffic never touches its phase.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      presc_p0 <= '0;
    end else if (tick_p0) begin
      presc_p0 <= '0;
    end else begin
      presc_p0 <= presc_p0 + 16'd1;
    end
  end

  // mtime: a write to either half overrides the increment for that cycle.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      mtime_p0 <= '0;
    end else if (wr_mtime_p0) begin
      if (addr_i == ADDR_MTIME_LO) begin
        mtime_p0[31:0] <= wdata_i;
      end else begin
        mtime_p0[63:32] <= wdata_i;
      end
    end else if (tick_p0) begin
      mtime_p0 <= mtime_p0 + 64'd1;
    end
  end

  // mtimecmp and msip write ports.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      mtimecmp_p0 <= '1;
      msip_p0     <= 1'b0;
    end else if (wr_p0) begin
      case (addr_i)
        ADDR_MSIP:     msip_p0             <= wdata_i[0];
        ADDR_MTCMP_LO: mtimecmp_p0[31:0]  <= wdata_i;
        ADDR_MTCMP_HI: mtimecmp_p0[63:32] <= wdata_i;
        default:       ;
      endcase
    end
  end

  // ---- stage p0 -> p1: bus response and registered interrupt lines ----
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      vld_p1    <= 1'b0;
      rdata_p1  <= '0;
      irq_sw_p1 <= 1'b0;
      irq_tm_p1 <= 1'b0;
    end else begin
      vld_p1    <= req_i;
      rdata_p1  <= rd_p0 ? read_mux(addr_i, mtime_p0, mtimecmp_p0, msip_p0) : '0;
      irq_sw_p1 <= msip_p0;
      irq_tm_p1 <= (mtime_p0 >= mtimecmp_p0);
    end
  end

  assign ack_o          = vld_p1;
  assign rdata_o        = rdata_p1;
  assign irq_software_o = irq_sw_p1;
  assign irq_timer_o    = irq_tm_p1;

endmodule
